// File: rtl/rc4_keysched.sv
// rc4_keysched: RC4 state-array sequencer (S[i]=i fill, then key-schedule swaps) on one external
// single-port S RAM with one-cycle read latency. Define RC4_PRGA_EN to add the keystream phase.
module rc4_keysched #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned KEY_BYTES = 3,
    parameter int unsigned KS_LEN    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [DATA_W-1:0]      addr,
    input  logic [DATA_W-1:0]      rddata,
    output logic [DATA_W-1:0]      wrdata,
    output logic                   wren,
    output logic [DATA_W-1:0]      ks_data,
    output logic                   ks_valid,
    input  logic                   ks_ready
);
    localparam int unsigned KEY_W  = 8 * KEY_BYTES;
    localparam int unsigned KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [DATA_W-1:0] LAST_IDX  = '1;
    localparam logic [KIDX_W-1:0] LAST_KIDX = KIDX_W'(KEY_BYTES - 1);

    typedef enum logic [4:0] {
        S_IDLE, S_INIT, S_RDI, S_CAPI, S_RDJ, S_CAPJ, S_WRJ, S_WRI,
`ifdef RC4_PRGA_EN
        S_P_RDI, S_P_CAPI, S_P_RDJ, S_P_CAPJ, S_P_WRI, S_P_WRJ, S_P_RDK, S_P_CAPK, S_P_OUT,
`endif
        S_DONE
    } state_t;

    state_t             r_state, w_state_nx;
    logic [DATA_W-1:0]  r_i, w_i_nx, r_j, w_j_nx;
    logic [DATA_W-1:0]  r_si, w_si_nx, r_sj, w_sj_nx;
    logic [KIDX_W-1:0]  r_kidx, w_kidx_nx;
    logic [KEY_W-1:0]   r_key, w_key_nx;
    logic               r_rdy, w_rdy_nx;
    logic               r_wren, w_wren_nx;
    logic [DATA_W-1:0]  r_addr, w_addr_nx, r_wrdata, w_wrdata_nx;
    logic [7:0]         w_keybyte;
    logic [DATA_W-1:0]  w_i_inc, w_j_ksa;
    logic [KIDX_W-1:0]  w_kidx_inc;

`ifdef RC4_PRGA_EN
    localparam int unsigned CNT_W = (KS_LEN > 1) ? $clog2(KS_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KS_LEN - 1);
    logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic [DATA_W-1:0]  r_ks_data, w_ks_data_nx;
    logic               r_ks_valid, w_ks_valid_nx;
    logic [DATA_W-1:0]  w_j_prga;
`endif

    // Key byte 0 sits in the MSBs of the latched key.
    always_comb begin
        w_keybyte = r_key[KEY_W-1 -: 8];
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (r_kidx == KIDX_W'(k)) w_keybyte = r_key[KEY_W-1-8*k -: 8];
        end
    end

    assign w_i_inc    = r_i + DATA_W'(1);
    assign w_j_ksa    = r_j + rddata + DATA_W'(w_keybyte);
    assign w_kidx_inc = (r_kidx == LAST_KIDX) ? '0 : r_kidx + KIDX_W'(1);
`ifdef RC4_PRGA_EN
    assign w_j_prga   = r_j + rddata;
`endif

    // Next-state and next-output logic; outputs are registered for the state being entered.
    always_comb begin
        w_state_nx  = r_state;
        w_i_nx      = r_i;
        w_j_nx      = r_j;
        w_si_nx     = r_si;
        w_sj_nx     = r_sj;
        w_kidx_nx   = r_kidx;
        w_key_nx    = r_key;
        w_rdy_nx    = 1'b0;
        w_wren_nx   = 1'b0;
        w_addr_nx   = r_addr;
        w_wrdata_nx = r_wrdata;
`ifdef RC4_PRGA_EN
        w_cnt_nx      = r_cnt;
        w_ks_data_nx  = r_ks_data;
        w_ks_valid_nx = r_ks_valid;
`endif
        unique case (r_state)
            S_IDLE, S_DONE: begin
                w_rdy_nx = 1'b1;
                if (r_rdy && en) begin
                    w_state_nx  = S_INIT;
                    w_rdy_nx    = 1'b0;
                    w_key_nx    = key;
                    w_i_nx      = '0;
                    w_j_nx      = '0;
                    w_kidx_nx   = '0;
                    w_wren_nx   = 1'b1;
                    w_addr_nx   = '0;
                    w_wrdata_nx = '0;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_INIT: begin
                if (r_i == LAST_IDX) begin
                    w_state_nx = S_RDI;
                    w_i_nx     = '0;
                    w_addr_nx  = '0;
                end else begin
                    w_i_nx      = w_i_inc;
                    w_wren_nx   = 1'b1;
                    w_addr_nx   = w_i_inc;
                    w_wrdata_nx = w_i_inc;
                end
            end
            S_RDI: w_state_nx = S_CAPI;
            S_CAPI: begin
                w_si_nx    = rddata;
                w_j_nx     = w_j_ksa;
                w_addr_nx  = w_j_ksa;
                w_state_nx = S_RDJ;
            end
            S_RDJ: w_state_nx = S_CAPJ;
            S_CAPJ: begin
                w_sj_nx     = rddata;
                w_wren_nx   = 1'b1;
                w_addr_nx   = r_j;
                w_wrdata_nx = r_si;
                w_state_nx  = S_WRJ;
            end
            S_WRJ: begin
                w_wren_nx   = 1'b1;
                w_addr_nx   = r_i;
                w_wrdata_nx = r_sj;
                w_state_nx  = S_WRI;
            end
            S_WRI: begin
                w_kidx_nx = w_kidx_inc;
                if (r_i == LAST_IDX) begin
`ifdef RC4_PRGA_EN
                    w_state_nx = S_P_RDI;
                    w_i_nx     = DATA_W'(1);
                    w_j_nx     = '0;
                    w_addr_nx  = DATA_W'(1);
                    w_cnt_nx   = '0;
`else
                    w_state_nx = S_DONE;
                    w_rdy_nx   = 1'b1;
`endif
                end else begin
                    w_i_nx     = w_i_inc;
                    w_addr_nx  = w_i_inc;
                    w_state_nx = S_RDI;
                end
            end
`ifdef RC4_PRGA_EN
            S_P_RDI: w_state_nx = S_P_CAPI;
            S_P_CAPI: begin
                w_si_nx    = rddata;
                w_j_nx     = w_j_prga;
                w_addr_nx  = w_j_prga;
                w_state_nx = S_P_RDJ;
            end
            S_P_RDJ: w_state_nx = S_P_CAPJ;
            S_P_CAPJ: begin
                w_sj_nx     = rddata;
                w_wren_nx   = 1'b1;
                w_addr_nx   = r_i;
                w_wrdata_nx = rddata;
                w_state_nx  = S_P_WRI;
            end
            S_P_WRI: begin
                w_wren_nx   = 1'b1;
                w_addr_nx   = r_j;
                w_wrdata_nx = r_si;
                w_state_nx  = S_P_WRJ;
            end
            S_P_WRJ: begin
                w_addr_nx  = r_si + r_sj;
                w_state_nx = S_P_RDK;
            end
            S_P_RDK: w_state_nx = S_P_CAPK;
            S_P_CAPK: begin
                w_ks_data_nx  = rddata;
                w_ks_valid_nx = 1'b1;
                w_state_nx    = S_P_OUT;
            end
            // Holds the byte with no memory traffic until the sink takes it.
            S_P_OUT: begin
                if (ks_ready) begin
                    w_ks_valid_nx = 1'b0;
                    if (r_cnt == LAST_CNT) begin
                        w_state_nx = S_DONE;
                        w_rdy_nx   = 1'b1;
                    end else begin
                        w_cnt_nx   = r_cnt + CNT_W'(1);
                        w_i_nx     = w_i_inc;
                        w_addr_nx  = w_i_inc;
                        w_state_nx = S_P_RDI;
                    end
                end
            end
`endif
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_i      <= '0;
            r_j      <= '0;
            r_si     <= '0;
            r_sj     <= '0;
            r_kidx   <= '0;
            r_key    <= '0;
            r_rdy    <= 1'b0;
            r_wren   <= 1'b0;
            r_addr   <= '0;
            r_wrdata <= '0;
`ifdef RC4_PRGA_EN
            r_cnt      <= '0;
            r_ks_data  <= '0;
            r_ks_valid <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nx;
            r_i      <= w_i_nx;
            r_j      <= w_j_nx;
            r_si     <= w_si_nx;
            r_sj     <= w_sj_nx;
            r_kidx   <= w_kidx_nx;
            r_key    <= w_key_nx;
            r_rdy    <= w_rdy_nx;
            r_wren   <= w_wren_nx;
            r_addr   <= w_addr_nx;
            r_wrdata <= w_wrdata_nx;
`ifdef RC4_PRGA_EN
            r_cnt      <= w_cnt_nx;
            r_ks_data  <= w_ks_data_nx;
            r_ks_valid <= w_ks_valid_nx;
`endif
        end
    end

    assign rdy    = r_rdy;
    assign wren   = r_wren;
    assign addr   = r_addr;
    assign wrdata = r_wrdata;
`ifdef RC4_PRGA_EN
    assign ks_data  = r_ks_data;
    assign ks_valid = r_ks_valid;
`else
    logic w_unused;
    assign w_unused = ks_ready;
    assign ks_data  = '0;
    assign ks_valid = 1'b0;
`endif

endmodule

// File: tb/tb_rc4_keysched.sv
// tb_rc4_keysched: drives an 8-bit/3-byte-key and a 4-bit/1-byte-key instance, each with its own
// S RAM, and checks S contents, latency, handshakes and (with RC4_PRGA_EN) the keystream.
module tb_rc4_keysched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en8, rdy8, wren8, ks_valid8, ks_ready8;
    logic [23:0] key8;
    logic [7:0]  addr8, rddata8, wrdata8, ks_data8;
    logic        en4, rdy4, wren4, ks_valid4, ks_ready4;
    logic [7:0]  key4;
    logic [3:0]  addr4, rddata4, wrdata4, ks_data4;

    rc4_keysched #(.DATA_W(8), .KEY_BYTES(3), .KS_LEN(10)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .rdy(rdy8), .key(key8), .addr(addr8),
        .rddata(rddata8), .wrdata(wrdata8), .wren(wren8), .ks_data(ks_data8),
        .ks_valid(ks_valid8), .ks_ready(ks_ready8));

    rc4_keysched #(.DATA_W(4), .KEY_BYTES(1), .KS_LEN(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .rdy(rdy4), .key(key4), .addr(addr4),
        .rddata(rddata4), .wrdata(wrdata4), .wren(wren4), .ks_data(ks_data4),
        .ks_valid(ks_valid4), .ks_ready(ks_ready4));

    // Synchronous single-port RAMs, read data one cycle after the address.
    logic [7:0] mem8 [256];
    logic [3:0] mem4 [16];
    always @(posedge clk) begin
        if (wren8) mem8[addr8] <= wrdata8;
        rddata8 <= mem8[addr8];
        if (wren4) mem4[addr4] <= wrdata4;
        rddata4 <= mem4[addr4];
    end

    int checks = 0;
    int failures = 0;
    int sel = 8;
    int model_s [256];
    logic        cur_rdy, cur_wren;
    logic [31:0] cur_addr, cur_wrdata;

    always_comb begin
        if (sel == 8) begin
            cur_rdy = rdy8; cur_wren = wren8;
            cur_addr = 32'(addr8); cur_wrdata = 32'(wrdata8);
        end else begin
            cur_rdy = rdy4; cur_wren = wren4;
            cur_addr = 32'(addr4); cur_wrdata = 32'(wrdata4);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference RC4 key schedule over an n-entry array, key byte k = k-th byte from the MSB end.
    task automatic model_ksa(input int n, input int nkb, input logic [23:0] k);
        int j, t, kb;
        for (int i = 0; i < n; i++) model_s[i] = i;
        j = 0;
        for (int i = 0; i < n; i++) begin
            kb = int'((k >> (8 * (nkb - 1 - (i % nkb)))) & 24'hFF);
            j = (j + model_s[i] + kb) % n;
            t = model_s[i]; model_s[i] = model_s[j]; model_s[j] = t;
        end
    endtask

    task automatic check_mem(input int s, input string tag);
        int n;
        n = (s == 8) ? 256 : 16;
        for (int i = 0; i < n; i++)
            chk($sformatf("%s[%0d]", tag, i), (s == 8) ? 32'(mem8[i]) : 32'(mem4[i]), 32'(model_s[i]));
    endtask

    // Presents en for one edge; returns #1 after that edge (cycle 1 of the run).
    task automatic start(input int s, input logic [23:0] k);
        sel = s;
        @(negedge clk);
        if (s == 8) begin key8 = k; en8 = 1'b1; end
        else begin key4 = k[7:0]; en4 = 1'b1; end
        @(posedge clk); #1;
        en8 = 1'b0; en4 = 1'b0;
    endtask

    // Follows a run from cycle 1 until rdy rises (bounded); lat = cycle index of rdy.
    task automatic wait_done(input int n, input bit noise, output int lat);
        int cyc;
        bit done;
        cyc = 1; done = 1'b0;
        while (!done) begin
            if (cyc == 1) begin
                chk("init_first_wren", 32'(cur_wren), 32'd1);
                chk("init_first_addr", cur_addr, 32'd0);
            end
            if (cyc == n) begin
                chk("init_last_addr", cur_addr, 32'(n - 1));
                chk("init_last_wrdata", cur_wrdata, 32'(n - 1));
            end
            if (cyc == n + 1) chk("ksa_first_wren", 32'(cur_wren), 32'd0);
            if (cur_rdy === 1'b1 || cyc > 8 * n + 8) begin
                done = 1'b1;
            end else begin
                if (noise) begin
                    if (cyc < 7 * n - 4) begin
                        if (sel == 8) begin en8 = 1'($urandom_range(0, 1)); key8 = 24'($urandom); end
                        else begin en4 = 1'($urandom_range(0, 1)); key4 = 8'($urandom); end
                    end else begin
                        en8 = 1'b0; en4 = 1'b0;
                    end
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        lat = cyc;
    endtask

    initial begin
        int lat;
        logic [23:0] k;
`ifdef RC4_PRGA_EN
        logic [7:0] golden [10];
        int exp_ks [10];
        int pi, pj, t, got, cyc;
        bit stalled, just_acc;
        logic [7:0] held;
`endif
        rst_n = 1'b0; en8 = 1'b0; en4 = 1'b0; key8 = '0; key4 = '0;
        ks_ready8 = 1'b0; ks_ready4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy8", 32'(rdy8), 32'd0);
        chk("rst_wren8", 32'(wren8), 32'd0);
        chk("rst_addr8", 32'(addr8), 32'd0);
        chk("rst_wrdata8", 32'(wrdata8), 32'd0);
        chk("rst_ks_valid8", 32'(ks_valid8), 32'd0);
        chk("rst_ks_data8", 32'(ks_data8), 32'd0);
        chk("rst_rdy4", 32'(rdy4), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_rdy8", 32'(rdy8), 32'd1);
        chk("post_rst_rdy4", 32'(rdy4), 32'd1);

`ifndef RC4_PRGA_EN
        // Golden 256-entry schedule and its latency.
        start(8, 24'h00033C);
        wait_done(256, 1'b0, lat);
        chk("lat8_golden", 32'(lat), 32'd1793);
        model_ksa(256, 3, 24'h00033C);
        check_mem(8, "s8_golden");

        start(4, 24'h0000A5);
        wait_done(16, 1'b0, lat);
        chk("lat4_a5", 32'(lat), 32'd113);
        model_ksa(16, 1, 24'h0000A5);
        check_mem(4, "s4_a5");

        // Random keys with en pulses and key changes while busy.
        repeat (3) begin
            k = 24'($urandom_range(0, 255));
            start(4, k);
            wait_done(16, 1'b1, lat);
            chk("lat4_noise", 32'(lat), 32'd113);
            model_ksa(16, 1, k);
            check_mem(4, "s4_noise");
        end
        k = 24'($urandom);
        start(8, k);
        wait_done(256, 1'b1, lat);
        chk("lat8_noise", 32'(lat), 32'd1793);
        model_ksa(256, 3, k);
        check_mem(8, "s8_noise");

        // Reset in the middle of the i=100 swap, then a clean run.
        k = 24'($urandom);
        start(8, k);
        repeat (859) @(posedge clk);
        #1;
        chk("mid_run_busy", 32'(rdy8), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_wren", 32'(wren8), 32'd0);
        chk("abort_rdy", 32'(rdy8), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_release_rdy", 32'(rdy8), 32'd1);
        k = 24'($urandom);
        start(8, k);
        wait_done(256, 1'b0, lat);
        chk("lat8_after_abort", 32'(lat), 32'd1793);
        model_ksa(256, 3, k);
        check_mem(8, "s8_after_abort");

        // en held high: runs restart back-to-back with a fresh key latched each time.
        sel = 4;
        @(negedge clk);
        k = 24'($urandom_range(0, 255));
        key4 = k[7:0]; en4 = 1'b1;
        @(posedge clk); #1;
        for (int r = 0; r < 3; r++) begin
            wait_done(16, 1'b0, lat);
            chk("lat4_b2b", 32'(lat), 32'd113);
            model_ksa(16, 1, k);
            check_mem(4, "s4_b2b");
            k = 24'($urandom_range(0, 255));
            key4 = k[7:0];
            if (r == 2) en4 = 1'b0;
            @(posedge clk); #1;
        end
        chk("b2b_idle_rdy", 32'(rdy4), 32'd1);
        chk("ks_valid_tied", 32'(ks_valid8), 32'd0);
        chk("ks_data_tied", 32'(ks_data8), 32'd0);
`else
        golden = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        model_ksa(256, 3, 24'h4B6579);
        pi = 0; pj = 0;
        for (int b = 0; b < 10; b++) begin
            pi = (pi + 1) % 256;
            pj = (pj + model_s[pi]) % 256;
            t = model_s[pi]; model_s[pi] = model_s[pj]; model_s[pj] = t;
            exp_ks[b] = model_s[(model_s[pi] + model_s[pj]) % 256];
        end
        start(8, 24'h4B6579);
        got = 0; cyc = 0; stalled = 1'b0; just_acc = 1'b0; held = '0;
        while (got < 10 && cyc < 20000) begin
            @(negedge clk);
            if (just_acc) chk("ks_single_present", 32'(ks_valid8), 32'd0);
            just_acc = 1'b0;
            ks_ready8 = 1'($urandom_range(0, 1));
            if (ks_valid8 === 1'b1) begin
                if (stalled) begin
                    chk("ks_hold_data", 32'(ks_data8), 32'(held));
                    chk("ks_stall_no_write", 32'(wren8), 32'd0);
                end
                if (ks_ready8) begin
                    chk($sformatf("ks_golden[%0d]", got), 32'(ks_data8), 32'(golden[got]));
                    chk($sformatf("ks_model[%0d]", got), 32'(ks_data8), 32'(exp_ks[got]));
                    got++;
                    stalled = 1'b0;
                    just_acc = 1'b1;
                end else begin
                    stalled = 1'b1;
                    held = ks_data8;
                end
            end
            cyc++;
        end
        chk("ks_count", 32'(got), 32'd10);
        @(negedge clk);
        ks_ready8 = 1'b0;
        chk("prga_done_rdy", 32'(rdy8), 32'd1);
        chk("prga_done_valid", 32'(ks_valid8), 32'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
